mux_sel_arbiter: RTL and testbench



---
 rtl/mux_sel_pkg.sv | 41 ++++
 rtl/mux_sel_arbiter_hold_reg.sv | 48 ++++
 rtl/mux_sel_arbiter.sv | 115 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_sel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_pkg
//  Description : Shared encodings for the mux select arbiter: mux select
//                codes, arbiter state encoding and channel identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_sel_pkg;

    // Mux select codes driven on ES; 2'b11 is never produced.
    localparam logic [1:0] ES_A    = 2'b00;
    localparam logic [1:0] ES_B    = 2'b01;
    localparam logic [1:0] ES_ZERO = 2'b10;

    // Arbiter state encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } state_t;

    // Channel identifiers used to remember the most recent grant.
    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } ch_t;

    // Select code presented to the mux while in a given state.
    function automatic logic [1:0] state_to_es(input state_t st);
        logic [1:0] es;
        es = ES_ZERO;
        case (st)
            GRANT_A: es = ES_A;
            GRANT_B: es = ES_B;
            default: es = ES_ZERO;
        endcase
        return es;
    endfunction

endpackage : mux_sel_pkg
`default_nettype wire

// File: rtl/mux_sel_arbiter_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module      : hold_reg
//  Description : One-entry operand holding register with a valid/ready
//                input side. The data stays stable while full and keeps its
//                last value after being consumed; only the full flag clears.
//  Revision    : 1.0 - initial release
// ============================================================================
module hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             clr,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Ready comes from the registered flag, so an entry drained on an edge
    // cannot be refilled on that same edge.
    assign in_ready = !r_full && !rst;
    assign data     = r_data;
    assign full     = r_full;

    // Capture an offered operand when empty; release the entry on clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else begin
            if (clr) begin
                r_full <= 1'b0;
            end
            if (in_valid && in_ready) begin
                r_full <= 1'b1;
                r_data <= in_data;
            end
        end
    end

endmodule : hold_reg
`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_sel_arbiter
//  Description : Feeds a 2-source output mux from two valid/ready channels.
//                Each channel has a one-entry holding register; a round-robin
//                FSM selects which held operand the mux presents on Y and
//                handshakes it to the downstream consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_sel_arbiter
    import mux_sel_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [1:0]       ES,
    output logic             y_valid,
    input  logic             y_ready
);

    state_t     r_state;
    state_t     w_state_next;
    ch_t        r_last_grant;
    ch_t        w_last_grant_next;
    logic [1:0] r_es;
    logic       r_y_valid;
    logic       w_a_full;
    logic       w_b_full;
    logic       w_decide;
    logic       w_clr_a;
    logic       w_clr_b;
    logic       w_elig_a;
    logic       w_elig_b;

    hold_reg #(.WIDTH(WIDTH)) u_hold_a (
        .clk      (clk),
        .rst      (rst),
        .in_valid (a_valid),
        .in_data  (a_data),
        .in_ready (a_ready),
        .clr      (w_clr_a),
        .data     (A),
        .full     (w_a_full)
    );

    hold_reg #(.WIDTH(WIDTH)) u_hold_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (b_valid),
        .in_data  (b_data),
        .in_ready (b_ready),
        .clr      (w_clr_b),
        .data     (B),
        .full     (w_b_full)
    );

    assign ES      = r_es;
    assign y_valid = r_y_valid;

    // Next-state: decide on idle or on a completed Y handshake, drain the
    // consumed entry, and pick among the remaining full entries round-robin.
    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_decide          = (r_state == IDLE) || (r_y_valid && y_ready);
        w_clr_a           = w_decide && (r_state == GRANT_A);
        w_clr_b           = w_decide && (r_state == GRANT_B);
        // Flags as registered before this edge; newly captured operands are
        // only seen on the following edge.
        w_elig_a          = w_a_full && (r_state != GRANT_A);
        w_elig_b          = w_b_full && (r_state != GRANT_B);
        if (w_decide) begin
            if (w_elig_a && w_elig_b) begin
                w_state_next = (r_last_grant == CH_A) ? GRANT_B : GRANT_A;
            end else if (w_elig_a) begin
                w_state_next = GRANT_A;
            end else if (w_elig_b) begin
                w_state_next = GRANT_B;
            end else begin
                w_state_next = IDLE;
            end
            if (w_state_next == GRANT_A) begin
                w_last_grant_next = CH_A;
            end else if (w_state_next == GRANT_B) begin
                w_last_grant_next = CH_B;
            end
        end
    end

    // State, grant history and the registered mux select / Y valid outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= CH_B;
            r_es         <= ES_ZERO;
            r_y_valid    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_es         <= state_to_es(w_state_next);
            r_y_valid    <= (w_state_next != IDLE);
        end
    end

endmodule : mux_sel_arbiter
`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_sel_arbiter
//  Description : Self-checking bench for mux_sel_arbiter: table of cycle
//                vectors, round-robin saturation run and mid-operation reset,
//                with a per-channel operand scoreboard on the Y handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_sel_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0;
    logic [3:0] a_data = 4'h0;
    logic       a_ready;
    logic       b_valid = 1'b0;
    logic [3:0] b_data = 4'h0;
    logic       b_ready;
    logic [3:0] A;
    logic [3:0] B;
    logic [1:0] ES;
    logic       y_valid;
    logic       y_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] qa[$];
    logic [3:0] qb[$];
    bit acc_a, acc_b, xfer;

    typedef struct {
        logic       rst;
        logic       av;
        logic [3:0] ad;
        logic       bv;
        logic [3:0] bd;
        logic       yr;
        logic       ar;
        logic       br;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [1:0] es;
        logic       yv;
    } vec_t;

    vec_t tbl[23];

    mux_sel_arbiter #(.WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_data  (a_data),
        .a_ready (a_ready),
        .b_valid (b_valid),
        .b_data  (b_data),
        .b_ready (b_ready),
        .A       (A),
        .B       (B),
        .ES      (ES),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [3:0] ad,
                         input logic bv, input logic [3:0] bd, input logic yr);
        rst = r; a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
    endtask

    // Sample handshakes mid-cycle, then advance to just after the next edge.
    task automatic tick();
        logic [3:0] exp_d;
        @(negedge clk);
        acc_a = 0; acc_b = 0; xfer = 0;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (y_valid && y_ready) begin
                xfer = 1;
                if (ES == 2'b00) begin
                    if (qa.size() == 0) check("sb_a_empty", 0, 8'd1, 8'd0);
                    else begin exp_d = qa.pop_front(); check("sb_a", 0, {4'h0, A}, {4'h0, exp_d}); end
                end else if (ES == 2'b01) begin
                    if (qb.size() == 0) check("sb_b_empty", 0, 8'd1, 8'd0);
                    else begin exp_d = qb.pop_front(); check("sb_b", 0, {4'h0, B}, {4'h0, exp_d}); end
                end else begin
                    check("sb_es_valid", 0, {6'h0, ES}, 8'h00);
                end
            end
            if (a_valid && a_ready) begin qa.push_back(a_data); acc_a = 1; end
            if (b_valid && b_ready) begin qb.push_back(b_data); acc_b = 1; end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst av ad bv bd yr | a_ready b_ready A B ES y_valid
        tbl[0]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b10, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4'hF, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'b10, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'h5, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h5, 4'h0, 2'b10, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h5, 4'h0, 2'b00, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h5, 4'h0, 2'b10, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 2'b10, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0, 4'h3, 4'hC, 2'b10, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h3, 4'hC, 2'b00, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h3, 4'hC, 2'b01, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h3, 4'hC, 2'b10, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 4'h6, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 4'h6, 4'h7, 2'b10, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h6, 4'h7, 2'b00, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 4'h6, 4'h7, 2'b01, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h6, 4'h7, 2'b10, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 4'h0, 1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 4'h6, 4'h9, 2'b10, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h6, 4'h9, 2'b01, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h2, 4'h9, 2'b01, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h2, 4'h9, 2'b01, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h2, 4'h9, 2'b01, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h2, 4'h9, 2'b01, 1'b1};
        tbl[20] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h2, 4'h9, 2'b01, 1'b1};
        tbl[21] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 4'h2, 4'h9, 2'b00, 1'b1};
        tbl[22] = '{1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'h2, 4'h9, 2'b10, 1'b0};

        // Table: reset, single A latency, ties, backpressure.
        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].rst, tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].yr);
            tick();
            check("a_ready", i, {7'h0, a_ready}, {7'h0, tbl[i].ar});
            check("b_ready", i, {7'h0, b_ready}, {7'h0, tbl[i].br});
            check("A", i, {4'h0, A}, {4'h0, tbl[i].ea});
            check("B", i, {4'h0, B}, {4'h0, tbl[i].eb});
            check("ES", i, {6'h0, ES}, {6'h0, tbl[i].es});
            check("y_valid", i, {7'h0, y_valid}, {7'h0, tbl[i].yv});
        end

        // Saturation: both sources always valid with incrementing data.
        begin
            logic [3:0] cnta;
            logic [3:0] cntb;
            logic [1:0] last_es;
            bit         have_last;
            bit         prev_yv;
            int         n_xfer;
            cnta = 4'h1; cntb = 4'h8; have_last = 0; prev_yv = 1; n_xfer = 0;
            drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
            tick();
            for (int k = 1; k <= 30; k++) begin
                drive(1'b0, 1'b1, cnta, 1'b1, cntb, 1'b1);
                tick();
                if (acc_a) cnta = cnta + 4'h1;
                if (acc_b) cntb = cntb + 4'h1;
                if (xfer) n_xfer++;
                check("sat_es_legal", k, {7'h0, (ES == 2'b11)}, 8'h00);
                if (k >= 3) begin
                    if (y_valid) begin
                        if (have_last) check("sat_alternate", k, {7'h0, (ES == last_es)}, 8'h00);
                    end else begin
                        check("sat_no_double_idle", k, {7'h0, prev_yv}, 8'h01);
                    end
                end
                if (y_valid) begin last_es = ES; have_last = 1; end
                prev_yv = y_valid;
            end
            check("sat_throughput", 0, {7'h0, (n_xfer >= 18)}, 8'h01);
            check("sat_qa_depth", 0, {7'h0, (qa.size() <= 1)}, 8'h01);
            check("sat_qb_depth", 0, {7'h0, (qb.size() <= 1)}, 8'h01);
        end

        // Mid-operation reset while in GRANT_A with B held.
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 4'h4, 1'b1, 4'h8, 1'b0);
        tick();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        tick();
        check("mr_grant_a", 0, {6'h0, ES}, 8'h00);
        check("mr_b_full", 0, {7'h0, b_ready}, 8'h00);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        tick();
        check("mr_es", 0, {6'h0, ES}, 8'h02);
        check("mr_y_valid", 0, {7'h0, y_valid}, 8'h00);
        check("mr_A", 0, {4'h0, A}, 8'h00);
        check("mr_B", 0, {4'h0, B}, 8'h00);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        #1;
        check("mr_a_ready", 0, {7'h0, a_ready}, 8'h01);
        check("mr_b_ready", 0, {7'h0, b_ready}, 8'h01);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("mr_idle_es", k, {6'h0, ES}, 8'h02);
            check("mr_idle_yv", k, {7'h0, y_valid}, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mux_sel_arbiter
`default_nettype wire
